// File: rtl/pio_button_input_if.sv
// Avalon-MM slave bus bundle for the input PIO (Altera PIO register map, read latency 1).
interface pio_button_input_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_button_input.sv
// Input PIO: 2-FF sync, per-bit debounce, edge capture with level IRQ, Avalon-MM slave.
// Debounce is built only when PIO_IN_DEBOUNCE_EN is defined; otherwise stable follows sync.
module pio_button_input #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19,
  parameter int IDLE_LEVEL      = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic [WIDTH-1:0]     in_pins,
  pio_button_input_if.slave    avs,
  output logic                 irq
);

  localparam logic             IDLE_BIT  = (IDLE_LEVEL != 0);
  localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;

  // Stage p0/p1: two-flop synchroniser for asynchronous board pins
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      sync_p0 <= IDLE_WORD;
      sync_p1 <= IDLE_WORD;
    end else begin
      sync_p0 <= in_pins;
      sync_p1 <= sync_p0;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  // Debounce stage: a bit is accepted only after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      stable <= IDLE_WORD;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  // Debounce bypassed: one extra register stage keeps the pin-to-data path at 3 cycles
  always_ff @(posedge in_clk) begin
    if (in_reset) stable <= IDLE_WORD;
    else          stable <= sync_p1;
  end
`endif

  // Edge stage: delayed copy of the accepted level
  always_ff @(posedge in_clk) begin
    if (in_reset) stable_d <= IDLE_WORD;
    else          stable_d <= stable;
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = stable_d & ~stable;
      1:       edge_hit = ~stable_d & stable;
      default: edge_hit = stable_d ^ stable;
    endcase
  end

  always_comb begin
    w1c = '0;
    if (avs.avs_write && (avs.avs_address == 2'd3)) w1c = avs.avs_writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      2'd0:    rd_mux = 32'(stable);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  // Register stage: new edges are ORed in after the clear so a coincident edge survives
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      irqmask          <= '0;
      edgecapture      <= '0;
      avs.avs_readdata <= '0;
    end else begin
      if (avs.avs_write && (avs.avs_address == 2'd2)) irqmask <= avs.avs_writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~w1c) | edge_hit;
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_button_input.sv
// Directed bench for pio_button_input (WIDTH=4, DEBOUNCE_CYCLES=4, falling edge, idle high).
module tb_pio_button_input;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int         LAT       = 6;
  localparam logic [3:0] GLITCH_EC = 4'h0;
`else
  localparam int         LAT       = 3;
  localparam logic [3:0] GLITCH_EC = 4'h1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pins;
  logic       irq;
  int         errors = 0;
  int         checks = 0;

  pio_button_input_if bus ();

  pio_button_input #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .IDLE_LEVEL(1), .EDGE_TYPE(0)
  ) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .in_pins (pins),
    .avs     (bus.slave),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.avs_address   = a;
    bus.avs_writedata = v;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    pins = 4'hF;
    bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (bus.avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=%h", bus.avs_readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_data got=%h exp=%h", d, 32'hF); end
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reserved got=%h exp=%h", d, 32'h0); end
    rd(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_irqmask got=%h exp=%h", d, 32'h0); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_edgecap got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    pins = 4'hE;
    repeat (3) tick();
    pins = 4'hF;
    repeat (10) tick();
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL glitch_data got=%h exp=%h", d, 32'hF); end
    rd(2'd3, d);
    checks++; if (d !== 32'(GLITCH_EC)) begin errors++; $display("FAIL glitch_edgecap got=%h exp=%h", d, 32'(GLITCH_EC)); end
    wr(2'd3, 32'hF);
    wr(2'd0, 32'h0);
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL data_write_ignored got=%h exp=%h", d, 32'hF); end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    logic [3:0]  exp_s;
    logic [3:0]  exp_e;
    pins = 4'hE;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      exp_s = (k >= LAT) ? 4'hE : 4'hF;
      exp_e = (k >= LAT + 1) ? 4'h1 : 4'h0;
      checks++; if (dut.stable !== exp_s) begin errors++; $display("FAIL latency_stable cyc=%0d got=%h exp=%h", k, dut.stable, exp_s); end
      checks++; if (dut.edgecapture !== exp_e) begin errors++; $display("FAIL latency_edgecap cyc=%0d got=%h exp=%h", k, dut.edgecapture, exp_e); end
    end
    rd(2'd0, d);
    checks++; if (d !== 32'hE) begin errors++; $display("FAIL latency_data got=%h exp=%h", d, 32'hE); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
    wr(2'd2, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got=%b exp=1", irq); end
    rd(2'd2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL irqmask_rb got=%h exp=%h", d, 32'h1); end
    wr(2'd3, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_edgecap got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    pins = 4'hC;
    repeat (LAT) tick();
    wr(2'd3, 32'h2);
    rd(2'd3, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL collision_edgecap got=%h exp=%h", d, 32'h2); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collision_irq got=%b exp=0", irq); end
  endtask

  task automatic test_read_clear();
    logic [31:0] d;
    bus.avs_address   = 2'd3;
    bus.avs_writedata = 32'h2;
    bus.avs_read      = 1'b1;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    checks++; if (bus.avs_readdata !== 32'h2) begin errors++; $display("FAIL rw_preclear got=%h exp=%h", bus.avs_readdata, 32'h2); end
    repeat (2) tick();
    checks++; if (bus.avs_readdata !== 32'h2) begin errors++; $display("FAIL readdata_hold got=%h exp=%h", bus.avs_readdata, 32'h2); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_cleared got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] d;
    logic [3:0]  exp_s;
    pins = 4'h8;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dut.stable !== 4'hF) begin errors++; $display("FAIL midreset_stable got=%h exp=%h", dut.stable, 4'hF); end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      exp_s = (k >= LAT) ? 4'h8 : 4'hF;
      checks++; if (dut.stable !== exp_s) begin errors++; $display("FAIL midreset_latency cyc=%0d got=%h exp=%h", k, dut.stable, exp_s); end
    end
    tick();
    rd(2'd3, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL midreset_edgecap got=%h exp=%h", d, 32'h7); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    wr(2'd2, 32'h4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL midreset_irq_unmask got=%b exp=1", irq); end
    rd(2'd0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL midreset_data got=%h exp=%h", d, 32'h8); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_irq();
    test_collision();
    test_read_clear();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
